// File: rtl/eth4to1_pll_ctrl.sv
// Reset and lock sequencer for the 156.25->312.5 MHz Ethernet fabric PLL.
// Runs entirely on the PLL reference clock: holds the PLL in reset, waits for
// a qualified lock, demands a stable lock window, then releases clk_ready_o.
// Failed lock attempts are retried up to MAX_RETRIES before parking in FAIL.
module eth4to1_pll_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             refclk_i,
    input  logic             rst_i,
    input  logic             pll_locked_i,
    input  logic             relock_req_i,
    output logic             pll_rst_o,
    output logic             clk_ready_o,
    output logic             fail_o,
    output logic [2:0]       state_o,
    output logic [2:0]       retry_cnt_o,
    output logic [CNT_W-1:0] lock_loss_cnt_o
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    // One timer shared by every state, sized for the longest interval.
    localparam int TMR_MAX = (RST_CYCLES > LOCK_TIMEOUT)
                           ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
                           : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    localparam int TMR_W = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] LOSS_MAX    = '1;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             sync1_q, locked_s_q;
    logic             pll_rst_q, clk_ready_q, fail_q;

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge refclk_i) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples
        // the pre-edge value of its neighbour; blocking here would collapse the
        // synchroniser into a single stage.
        if (rst_i) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= pll_locked_i;
            locked_s_q <= sync1_q;
        end
    end

    // Next-state, timer and counter decisions.
    always_comb begin
        // NOTE: every signal gets a default before the case so that paths which
        // do not assign it cannot infer a latch.
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        timer_d = timer_q + TMR_W'(1);

        if (relock_req_i) begin
            state_d = ST_RESET;
            retry_d = 3'd0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s_q) begin
                        state_d = ST_STABLE;
                    end else if (timer_q == LOCK_LAST) begin
                        retry_d = retry_q + 3'd1;
                        state_d = (retry_d == RETRY_MAX) ? ST_FAIL : ST_RESET;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s_q) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        retry_d = 3'd0;
                    end
                end
                ST_RUN: begin
                    if (!locked_s_q) begin
                        state_d = ST_RESET;
                        if (loss_q != LOSS_MAX) loss_d = loss_q + CNT_W'(1);
                    end
                end
                ST_FAIL: ;
                default: state_d = ST_RESET;
            endcase
        end

        // Timer restarts on every entry (including a relock while in RESET)
        // and idles in the states that do not time anything.
        if (relock_req_i || (state_d != state_q) ||
            (state_q == ST_RUN) || (state_q == ST_FAIL)) begin
            timer_d = '0;
        end
    end

    // State, counters and registered outputs; outputs follow the next state
    // so they always agree with state_o in the same cycle.
    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            state_q     <= ST_RESET;
            timer_q     <= '0;
            retry_q     <= 3'd0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            clk_ready_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= (state_d == ST_RESET) || (state_d == ST_FAIL);
            clk_ready_q <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
        end
    end

    assign state_o         = state_q;
    assign pll_rst_o       = pll_rst_q;
    assign clk_ready_o     = clk_ready_q;
    assign fail_o          = fail_q;
    assign retry_cnt_o     = retry_q;
    assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_eth4to1_pll_ctrl.sv
// Bench for eth4to1_pll_ctrl: directed stimulus pushes the expected output
// changes (with the cycle they must appear on) into a queue; a monitor pops
// one entry every time the DUT output vector changes and compares it.
module tb_eth4to1_pll_ctrl;

    localparam int CNT_W = 2;
    localparam logic [2:0] S_RESET = 3'd0, S_WAIT = 3'd1, S_STABLE = 3'd2,
                           S_RUN = 3'd3, S_FAIL = 3'd4;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic [2:0] rc;
        logic [1:0] ll;
    } exp_t;

    logic             refclk = 1'b0;
    logic             rst = 1'b1;
    logic             pll_locked = 1'b0;
    logic             relock_req = 1'b0;
    logic             pll_rst, clk_ready, fail;
    logic [2:0]       state, retry_cnt;
    logic [CNT_W-1:0] lock_loss_cnt;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    eth4to1_pll_ctrl #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(8),
        .MAX_RETRIES(2), .CNT_W(CNT_W)
    ) dut (
        .refclk_i(refclk), .rst_i(rst), .pll_locked_i(pll_locked),
        .relock_req_i(relock_req), .pll_rst_o(pll_rst), .clk_ready_o(clk_ready),
        .fail_o(fail), .state_o(state), .retry_cnt_o(retry_cnt),
        .lock_loss_cnt_o(lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    // Posedge counter: after posedge N, cyc == N.
    always @(posedge refclk) cyc++;

    task automatic push(input int c, input logic [2:0] st, input logic [2:0] rc,
                        input logic [1:0] ll);
        exp_t e;
        e.cyc = c; e.st = st; e.rc = rc; e.ll = ll;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // Outputs sampled on the falling edge; every change consumes one expectation.
    logic [10:0] prev = 'x;
    always @(negedge refclk) begin
        logic [10:0] cur;
        exp_t        e;
        logic        e_pr, e_cr, e_fl;
        cur = {state, pll_rst, clk_ready, fail, retry_cnt, lock_loss_cnt};
        if (cur !== prev) begin
            prev = cur;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d state=%0d pll_rst=%b clk_ready=%b fail=%b retry=%0d loss=%0d",
                         cyc, state, pll_rst, clk_ready, fail, retry_cnt, lock_loss_cnt);
            end else begin
                e    = exp_q.pop_front();
                e_pr = (e.st == S_RESET) || (e.st == S_FAIL);
                e_cr = (e.st == S_RUN);
                e_fl = (e.st == S_FAIL);
                if (e.cyc != cyc || state !== e.st || pll_rst !== e_pr ||
                    clk_ready !== e_cr || fail !== e_fl || retry_cnt !== e.rc ||
                    lock_loss_cnt !== e.ll) begin
                    failures++;
                    $display("FAIL event (got/exp) cyc=%0d/%0d state=%0d/%0d pll_rst=%b/%b clk_ready=%b/%b fail=%b/%b retry=%0d/%0d loss=%0d/%0d",
                             cyc, e.cyc, state, e.st, pll_rst, e_pr, clk_ready, e_cr,
                             fail, e_fl, retry_cnt, e.rc, lock_loss_cnt, e.ll);
                end
            end
        end
    end

    // One-cycle lock drop while in RUN: RESET 3 edges later, 4-cycle hold,
    // immediate lock in WAIT_LOCK, 8 stable cycles back to RUN.
    task automatic drop_in_run(input logic [1:0] ll_after);
        int n;
        n = cyc;
        pll_locked = 1'b0;
        push(n + 3,  S_RESET,  3'd0, ll_after);
        push(n + 7,  S_WAIT,   3'd0, ll_after);
        push(n + 8,  S_STABLE, 3'd0, ll_after);
        push(n + 16, S_RUN,    3'd0, ll_after);
        tick(1);
        pll_locked = 1'b1;
        tick(20);
    endtask

    initial begin
        int n;
        // Reset values appear after the first edge with rst high.
        push(1, S_RESET, 3'd0, 2'd0);
        tick(3);
        rst = 1'b0;
        push(7, S_WAIT, 3'd0, 2'd0);

        // 1: lock rises 10 cycles after release; sampled at edge 14,
        //    2-flop latency then 8 stable cycles -> RUN at edge 24.
        tick(10);
        pll_locked = 1'b1;
        push(16, S_STABLE, 3'd0, 2'd0);
        push(24, S_RUN,    3'd0, 2'd0);
        tick(16);

        // 4: four lock losses in RUN; 2-bit counter saturates at 3.
        drop_in_run(2'd1);
        drop_in_run(2'd2);
        drop_in_run(2'd3);
        drop_in_run(2'd3);

        // 5: relock in RUN with lock held -> RESET next edge, loss count kept.
        n = cyc;
        relock_req = 1'b1;
        push(n + 1,  S_RESET,  3'd0, 2'd3);
        push(n + 5,  S_WAIT,   3'd0, 2'd3);
        push(n + 6,  S_STABLE, 3'd0, 2'd3);
        push(n + 14, S_RUN,    3'd0, 2'd3);
        tick(1);
        relock_req = 1'b0;
        tick(19);

        // 3: in STABLE, locked_s low for the cycle where the timer is 5 ->
        //    WAIT_LOCK, no retry, then a full 8 cycles before RUN.
        n = cyc;
        relock_req = 1'b1;
        push(n + 1,  S_RESET,  3'd0, 2'd3);
        push(n + 5,  S_WAIT,   3'd0, 2'd3);
        push(n + 6,  S_STABLE, 3'd0, 2'd3);
        push(n + 12, S_WAIT,   3'd0, 2'd3);
        push(n + 13, S_STABLE, 3'd0, 2'd3);
        push(n + 21, S_RUN,    3'd0, 2'd3);
        tick(1);
        relock_req = 1'b0;
        tick(8);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(15);

        // 2: lock never comes -> two 32-cycle windows, then FAIL.
        n = cyc;
        relock_req = 1'b1;
        pll_locked = 1'b0;
        push(n + 1,  S_RESET, 3'd0, 2'd3);
        push(n + 5,  S_WAIT,  3'd0, 2'd3);
        push(n + 37, S_RESET, 3'd1, 2'd3);
        push(n + 41, S_WAIT,  3'd1, 2'd3);
        push(n + 73, S_FAIL,  3'd2, 2'd3);
        tick(1);
        relock_req = 1'b0;
        tick(79);

        // relock out of FAIL clears fail and retry_cnt; one more timeout.
        n = cyc;
        relock_req = 1'b1;
        push(n + 1,  S_RESET, 3'd0, 2'd3);
        push(n + 5,  S_WAIT,  3'd0, 2'd3);
        push(n + 37, S_RESET, 3'd1, 2'd3);
        push(n + 41, S_WAIT,  3'd1, 2'd3);
        tick(1);
        relock_req = 1'b0;
        tick(49);

        // 6: rst together with relock mid-WAIT_LOCK (retry_cnt=1) -> full reset.
        n = cyc;
        rst = 1'b1;
        relock_req = 1'b1;
        push(n + 1, S_RESET, 3'd0, 2'd0);
        push(n + 5, S_WAIT,  3'd0, 2'd0);
        tick(1);
        rst = 1'b0;
        relock_req = 1'b0;
        tick(5);
        pll_locked = 1'b1;
        push(n + 9,  S_STABLE, 3'd0, 2'd0);
        push(n + 17, S_RUN,    3'd0, 2'd0);
        tick(16);

        // Every expected change must have been observed.
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events got=%0d exp=0 next_cyc=%0d",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
